// File: rtl/div_lz_unit.sv
// rtl/div_lz_unit.sv - multi-cycle restoring divider for MIPS DIV/DIVU with leading-zero skip
//
// Purpose:
//   Restoring divider for the EX stage. The dividend's leading-zero count
//   (from the upstream count_leading_zero) lets the unit skip the iterations
//   that can only produce zero quotient bits. Quotient goes to LO, remainder
//   to HI; div_done pulses once per completed operation.
//
// Build option:
//   DIV_EARLY_TERM_EN  defined   : N = 32 - div_a_lz, dividend pre-shifted by div_a_lz
//                      undefined : div_a_lz ignored, always 32 iterations
//
// Ports:
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   div_start   in   request, sampled only while div_ready=1
//   div_signed  in   1 = DIV (two's complement), 0 = DIVU
//   div_a       in   dividend (raw register value)
//   div_b       in   divisor (raw register value)
//   div_a_lz    in   leading zeros of |div_a| (0..32, larger values clamp to 32)
//   div_cancel  in   pipeline flush, aborts any operation in flight
//   div_ready   out  idle, able to accept div_start
//   div_busy    out  operation in flight
//   div_done    out  one-cycle pulse, div_q/div_r valid
//   div_q       out  quotient
//   div_r       out  remainder

module div_lz_unit #(
   parameter int DW  = 32,
   parameter int LZW = 6
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           div_start,
   input  logic           div_signed,
   input  logic [DW-1:0]  div_a,
   input  logic [DW-1:0]  div_b,
   input  logic [LZW-1:0] div_a_lz,
   input  logic           div_cancel,
   output logic           div_ready,
   output logic           div_busy,
   output logic           div_done,
   output logic [DW-1:0]  div_q,
   output logic [DW-1:0]  div_r
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t         r_state;
   logic [DW-1:0]  r_dvd;     // working dividend, consumed MSB first
   logic [DW-1:0]  r_absb;
   logic [DW-1:0]  r_quo;
   logic [DW-1:0]  r_rem;     // always < |b|, so DW bits suffice between steps
   logic [LZW-1:0] r_cnt;     // iterations still to run
   logic           r_sq;
   logic           r_sr;
   logic           r_dbz;
   logic           r_done;
   logic [DW-1:0]  r_q;
   logic [DW-1:0]  r_r;

   logic [DW-1:0]  w_abs_a;
   logic [DW-1:0]  w_abs_b;
   logic [LZW-1:0] w_shift;
   logic [LZW-1:0] w_n;
   logic [DW-1:0]  w_dvd_init;
   logic [DW:0]    w_rem_sh;
   logic           w_fits;
   logic [DW-1:0]  w_sub;
   logic [DW-1:0]  w_rem_next;

   assign w_abs_a = (div_signed && div_a[DW-1]) ? -div_a : div_a;
   assign w_abs_b = (div_signed && div_b[DW-1]) ? -div_b : div_b;

`ifdef DIV_EARLY_TERM_EN
   logic [LZW-1:0] w_lz_clamp;
   assign w_lz_clamp = (div_a_lz > LZW'(DW)) ? LZW'(DW) : div_a_lz;
   assign w_shift    = w_lz_clamp;
   assign w_n        = LZW'(DW) - w_lz_clamp;
`else
   logic w_unused_lz;
   assign w_unused_lz = ^div_a_lz;
   assign w_shift     = '0;
   assign w_n         = LZW'(DW);
`endif

   // A shift of DW (dividend zero) yields 0, which is what we want.
   assign w_dvd_init = w_abs_a << w_shift;

   // One restoring step: bring in the next dividend bit, try to subtract |b|.
   assign w_rem_sh   = {r_rem, r_dvd[DW-1]};
   assign w_fits     = (w_rem_sh >= {1'b0, r_absb});
   assign w_sub      = w_rem_sh[DW-1:0] - r_absb;   // exact when w_fits
   assign w_rem_next = w_fits ? w_sub : w_rem_sh[DW-1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_dvd   <= '0;
         r_absb  <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_cnt   <= '0;
         r_sq    <= 1'b0;
         r_sr    <= 1'b0;
         r_dbz   <= 1'b0;
         r_done  <= 1'b0;
         r_q     <= '0;
         r_r     <= '0;
      end else begin
         r_done <= 1'b0;
         if (div_cancel) begin
            // Flush wins over start and completion; results are left untouched.
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (div_start) begin
                     r_sq  <= div_signed & (div_a[DW-1] ^ div_b[DW-1]);
                     r_sr  <= div_signed & div_a[DW-1];
                     r_absb <= w_abs_b;
                     r_quo <= '0;
                     r_rem <= '0;
                     r_cnt <= w_n;
                     r_dbz <= (div_b == '0);
                     // Divide-by-zero reports the raw dividend, so park it here.
                     r_dvd <= (div_b == '0) ? div_a : w_dvd_init;
                     r_state <= S_ITER;
                  end
               end
               S_ITER: begin
                  // Special cases spend this one cycle without stepping, which
                  // lands their completion where a one-step divide would.
                  if (r_dbz || (r_cnt == '0)) begin
                     r_state <= S_FIX;
                  end else begin
                     r_rem <= w_rem_next;
                     r_quo <= {r_quo[DW-2:0], w_fits};
                     r_dvd <= {r_dvd[DW-2:0], 1'b0};
                     r_cnt <= r_cnt - 1'b1;
                     if (r_cnt == LZW'(1)) begin
                        r_state <= S_FIX;
                     end
                  end
               end
               S_FIX: begin
                  if (r_dbz) begin
                     r_q <= '1;
                     r_r <= r_dvd;
                  end else begin
                     // 0x80000000 / -1 falls out as q=0x80000000 since sq=0.
                     r_q <= r_sq ? -r_quo : r_quo;
                     r_r <= r_sr ? -r_rem : r_rem;
                  end
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign div_ready = (r_state == S_IDLE);
   assign div_busy  = (r_state != S_IDLE);
   assign div_done  = r_done;
   assign div_q     = r_q;
   assign div_r     = r_r;

endmodule

// File: tb/tb_div_lz_unit.sv
// tb/tb_div_lz_unit.sv - bench for div_lz_unit
module tb_div_lz_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [5:0]  div_a_lz;
   logic        div_cancel;
   logic        div_ready;
   logic        div_busy;
   logic        div_done;
   logic [31:0] div_q;
   logic [31:0] div_r;

   div_lz_unit #(.DW(32), .LZW(6)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .div_start  (div_start),
      .div_signed (div_signed),
      .div_a      (div_a),
      .div_b      (div_b),
      .div_a_lz   (div_a_lz),
      .div_cancel (div_cancel),
      .div_ready  (div_ready),
      .div_busy   (div_busy),
      .div_done   (div_done),
      .div_q      (div_q),
      .div_r      (div_r)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // expectation state
   bit          exp_pending   = 1'b0;
   bit          exp_cancelled = 1'b0;
   int          exp_e0        = 0;
   int          exp_end       = 0;
   logic [31:0] exp_q, exp_r;
   logic [31:0] held_q = '0;
   logic [31:0] held_r = '0;
   logic [31:0] cap_q  = '0;
   logic [31:0] cap_r  = '0;
   int          cap_cyc = 0;
   int          cap_cnt = 0;
   bit          busy_e, done_e;

`ifdef DIV_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic int clz_abs(input logic [31:0] a, input bit sgn);
      logic [31:0] m;
      m = (sgn && a[31]) ? -a : a;
      for (int i = 31; i >= 0; i--) if (m[i]) return 31 - i;
      return 32;
   endfunction

   function automatic void model_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                     output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   function automatic int model_lat(input logic [31:0] b, input int lz);
      int l;
      if (b == 32'd0) return 2;
      if (!EARLY) return 33;
      l = (lz > 32) ? 32 : lz;
      if (l == 32) return 2;
      return 32 - l + 1;
   endfunction

   // compare process: every cycle out of reset
   always @(negedge clk) begin
      if (resetn) begin
         busy_e = exp_pending && (cyc >= exp_e0) && (cyc < exp_end);
         done_e = exp_pending && !exp_cancelled && (cyc == exp_end);
         check("ready", div_ready, !busy_e);
         check("busy",  div_busy,  busy_e);
         check("done",  div_done,  done_e);
         if (div_done) begin
            cap_q   = div_q;
            cap_r   = div_r;
            cap_cyc = cyc;
            cap_cnt++;
         end
         if (done_e) begin
            held_q = exp_q;
            held_r = exp_r;
         end
         check("q", div_q, held_q);
         check("r", div_r, held_r);
         if (exp_pending && cyc >= exp_end) exp_pending = 1'b0;
      end
   end

   task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit sgn, input int lz);
      div_a      = a;
      div_b      = b;
      div_signed = sgn;
      div_a_lz   = 6'(lz);
      div_start  = 1'b1;
      model_div(a, b, sgn, exp_q, exp_r);
      exp_e0        = cyc + 1;
      exp_end       = exp_e0 + model_lat(b, lz);
      exp_cancelled = 1'b0;
      exp_pending   = 1'b1;
      @(negedge clk);
      #1;
      div_start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_pending && n < 100) begin
         @(negedge clk);
         n++;
      end
      #1;
      if (exp_pending) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: operation still pending after %0d cycles", n);
         exp_pending = 1'b0;
      end
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b, input bit sgn, input int lz);
      launch(a, b, sgn, lz);
      wait_idle();
   endtask

   logic [31:0] tv_a [10] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd5,
                              32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'd1, 32'hFFFF_FF9C, 32'd0};
   logic [31:0] tv_b [10] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'd1, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 32'd7, 32'd3};
   bit          tv_s [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

   int snap;

   initial begin
      resetn     = 1'b0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      div_a      = '0;
      div_b      = '0;
      div_a_lz   = '0;
      div_cancel = 1'b0;
      #12;
      check("rst_ready", div_ready, 1'b1);
      check("rst_busy",  div_busy,  1'b0);
      check("rst_done",  div_done,  1'b0);
      check("rst_q",     div_q,     32'd0);
      check("rst_r",     div_r,     32'd0);
      @(negedge clk);
      #1;
      resetn = 1'b1;

      // hand-computed vectors
      run(32'd100, 32'd7, 1'b0, 25);
      check("t1_q", cap_q, 32'd14);
      check("t1_r", cap_r, 32'd2);
      check("t1_lat", 32'(cap_cyc - exp_e0), EARLY ? 32'd8 : 32'd33);

      run(32'hFFFF_FFF9, 32'd2, 1'b1, 29);
      check("t2_q", cap_q, 32'hFFFF_FFFD);
      check("t2_r", cap_r, 32'hFFFF_FFFF);

      run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      check("t3_q", cap_q, 32'h8000_0000);
      check("t3_r", cap_r, 32'd0);
      check("t3_lat", 32'(cap_cyc - exp_e0), 32'd33);

      run(32'h1234, 32'd0, 1'b0, clz_abs(32'h1234, 1'b0));
      check("t4_q", cap_q, 32'hFFFF_FFFF);
      check("t4_r", cap_r, 32'h1234);
      check("t4_lat", 32'(cap_cyc - exp_e0), 32'd2);

      run(32'd0, 32'd5, 1'b0, 32);
      check("t4b_q", cap_q, 32'd0);
      check("t4b_r", cap_r, 32'd0);
      check("t4b_lat", 32'(cap_cyc - exp_e0), EARLY ? 32'd2 : 32'd33);

      // lz beyond 32 clamps
      run(32'd0, 32'd5, 1'b0, 40);
      check("clamp_lat", 32'(cap_cyc - exp_e0), EARLY ? 32'd2 : 32'd33);

      // table of further directed vectors, checked by the model
      for (int i = 0; i < 10; i++) run(tv_a[i], tv_b[i], tv_s[i], clz_abs(tv_a[i], tv_s[i]));

      // cancel mid-flight
      snap = cap_cnt;
      launch(32'hFFFF_FFFF, 32'd3, 1'b0, 0);
      while (cyc < exp_e0 + 5) @(negedge clk);
      #1;
      div_cancel    = 1'b1;
      exp_cancelled = 1'b1;
      exp_end       = cyc + 1;
      @(negedge clk);
      #1;
      div_cancel = 1'b0;
      check("cancel_ready", div_ready, 1'b1);
      repeat (40) @(negedge clk);
      #1;
      check("cancel_nodone", 32'(cap_cnt), 32'(snap));

      // start together with cancel in idle is dropped
      div_a      = 32'd9;
      div_b      = 32'd3;
      div_start  = 1'b1;
      div_cancel = 1'b1;
      @(negedge clk);
      #1;
      div_start  = 1'b0;
      div_cancel = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("cancel_prio", 32'(cap_cnt), 32'(snap));

      // start while busy is dropped, then back-to-back start during done
      launch(32'd100, 32'd7, 1'b0, 25);
      repeat (3) @(negedge clk);
      #1;
      div_a     = 32'd9;
      div_b     = 32'd3;
      div_start = 1'b1;
      @(negedge clk);
      #1;
      div_start = 1'b0;
      wait_idle();
      check("drop_q", cap_q, 32'd14);
      run(32'hFFFF_FF9C, 32'd7, 1'b1, clz_abs(32'hFFFF_FF9C, 1'b1));
      check("b2b_q", cap_q, 32'hFFFF_FFF2);
      check("b2b_r", cap_r, 32'hFFFF_FFFE);

      // reset mid-iteration
      launch(32'hFFFF_FFFF, 32'd3, 1'b0, 0);
      repeat (5) @(negedge clk);
      #1;
      resetn      = 1'b0;
      exp_pending = 1'b0;
      held_q      = '0;
      held_r      = '0;
      #1;
      check("mrst_ready", div_ready, 1'b1);
      check("mrst_busy",  div_busy,  1'b0);
      check("mrst_done",  div_done,  1'b0);
      check("mrst_q",     div_q,     32'd0);
      check("mrst_r",     div_r,     32'd0);
      @(negedge clk);
      #1;
      resetn = 1'b1;
      run(32'd20, 32'd6, 1'b0, clz_abs(32'd20, 1'b0));
      check("post_q", cap_q, 32'd3);
      check("post_r", cap_r, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
